// File: rtl/sot_align_pkg.sv
// Shared types and widths for the S-bit start-of-frame alignment supervisor.
// Holds the FSM encoding, the WAIT timer width and the retry counter width.
package sot_align_pkg;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_RUN    = 2'd2,
        ST_FAILED = 2'd3
    } state_t;

    localparam int TIMER_WIDTH = 16;
    localparam int RETRY_WIDTH = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used for per-link lock-loss counts.
// Clear beats increment so a clear request always wins over a same-cycle event.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sot_align_ctrl.sv
// Supervisor for the bank of S-bit frame aligners: reset sequencing, lock wait, run monitoring.
// Optional macro SOT_ALIGN_AUTO_MASK_EN auto-masks links still unlocked when retries run out.
module sot_align_ctrl
    import sot_align_pkg::*;
#(
    parameter int NUM_VFATS    = 24,
    parameter int RESET_CYCLES = 16,
    parameter int MAX_RETRIES  = 3,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                           clock,
    input  logic                           reset_i,
    input  logic [NUM_VFATS-1:0]           sot_is_aligned_i,
    input  logic [NUM_VFATS-1:0]           sot_unstable_i,
    input  logic [NUM_VFATS-1:0]           vfat_mask_i,
    input  logic [15:0]                    timeout_i,
    input  logic                           resync_req_i,
    input  logic                           cnt_reset_i,
    output logic [NUM_VFATS-1:0]           aligner_reset_o,
    output logic [NUM_VFATS-1:0]           auto_mask_o,
    output logic                           sot_ready_o,
    output logic                           align_failed_o,
    output logic [1:0]                     retry_cnt_o,
    output logic [NUM_VFATS*CNT_WIDTH-1:0] lock_loss_cnt_o
);

    localparam logic [TIMER_WIDTH-1:0] RESET_LAST  = TIMER_WIDTH'(RESET_CYCLES - 1);
    localparam int                     RETRY_MAX   = (1 << RETRY_WIDTH) - 1;
    localparam logic [RETRY_WIDTH-1:0] RETRY_LIMIT =
        RETRY_WIDTH'((MAX_RETRIES > RETRY_MAX) ? RETRY_MAX : MAX_RETRIES);

    state_t                 state;
    state_t                 state_nxt;
    logic [TIMER_WIDTH-1:0] timer;
    logic [TIMER_WIDTH-1:0] timer_nxt;
    logic [RETRY_WIDTH-1:0] retry_cnt;
    logic [RETRY_WIDTH-1:0] retry_nxt;
    logic [NUM_VFATS-1:0]   auto_mask;
    logic [NUM_VFATS-1:0]   auto_mask_nxt;

    logic [NUM_VFATS-1:0]   enabled;
    logic [NUM_VFATS-1:0]   fault_vec;
    logic [NUM_VFATS-1:0]   cnt_inc;
    logic                   all_locked;

    assign enabled    = ~vfat_mask_i & ~auto_mask;
    assign all_locked = &(sot_is_aligned_i | ~enabled);
    assign fault_vec  = enabled & (sot_unstable_i | ~sot_is_aligned_i);

    // A resync request pre-empts the FSM, so faults in that cycle are not counted.
    assign cnt_inc = ((state == ST_RUN) && !resync_req_i) ? fault_vec : '0;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        retry_nxt = retry_cnt;
`ifdef SOT_ALIGN_AUTO_MASK_EN
        auto_mask_nxt = auto_mask;
`else
        auto_mask_nxt = '0;
`endif

        if (resync_req_i) begin
            state_nxt     = ST_RESET;
            timer_nxt     = '0;
            retry_nxt     = '0;
            auto_mask_nxt = '0;
        end else begin
            case (state)
                ST_RESET: begin
                    if (timer == RESET_LAST) begin
                        state_nxt = ST_WAIT;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end

                ST_WAIT: begin
                    timer_nxt = timer + 1'b1;
                    if (all_locked) begin
                        state_nxt = ST_RUN;
                        timer_nxt = '0;
                    end else if (timer == timeout_i) begin
                        timer_nxt = '0;
                        if (retry_cnt < RETRY_LIMIT) begin
                            retry_nxt = retry_cnt + 1'b1;
                            state_nxt = ST_RESET;
                        end else begin
`ifdef SOT_ALIGN_AUTO_MASK_EN
                            // Give up on the stragglers only, then retry the rest from scratch.
                            auto_mask_nxt = auto_mask | (enabled & ~sot_is_aligned_i);
                            retry_nxt     = '0;
                            state_nxt     = ST_RESET;
`else
                            state_nxt = ST_FAILED;
`endif
                        end
                    end
                end

                ST_RUN: begin
                    if (|fault_vec) begin
                        state_nxt = ST_RESET;
                        timer_nxt = '0;
                        retry_nxt = '0;
                    end
                end

                ST_FAILED: begin
                    state_nxt = ST_FAILED;
                end

                default: begin
                    state_nxt = ST_RESET;
                    timer_nxt = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next-state view so they line up with the state register.
    always_ff @(posedge clock) begin
        if (reset_i) begin
            state           <= ST_RESET;
            timer           <= '0;
            retry_cnt       <= '0;
            auto_mask       <= '0;
            aligner_reset_o <= '1;
            sot_ready_o     <= 1'b0;
            align_failed_o  <= 1'b0;
        end else begin
            state           <= state_nxt;
            timer           <= timer_nxt;
            retry_cnt       <= retry_nxt;
            auto_mask       <= auto_mask_nxt;
            aligner_reset_o <= {NUM_VFATS{state_nxt == ST_RESET}};
            sot_ready_o     <= (state_nxt == ST_RUN) && (|(~vfat_mask_i & ~auto_mask_nxt));
            align_failed_o  <= (state_nxt == ST_FAILED);
        end
    end

    assign auto_mask_o = auto_mask;
    assign retry_cnt_o = retry_cnt;

    for (genvar i = 0; i < NUM_VFATS; i++) begin : g_cnt
        sat_counter #(
            .WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clock (clock),
            .reset (reset_i),
            .clr   (cnt_reset_i),
            .inc   (cnt_inc[i]),
            .count (lock_loss_cnt_o[CNT_WIDTH*i +: CNT_WIDTH])
        );
    end

endmodule
